// File: rtl/t02_wishbone_arbiter.sv
// t02_wishbone_arbiter
//   Round-robin arbiter and classic Wishbone single-cycle bus manager.
//   NUM_CH requestors raise level read/write requests. One channel is granted
//   at a time, and its address, data and select are latched onto the bus.
//   A single Wishbone read or write is run. The granted channel then gets a
//   one-cycle done pulse, and read data is returned on the shared ch_dat_o.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   en            : chip enable, low blocks new grants only
//   ch_re_i/we_i  : per-channel read/write request (level)
//   ch_adr_i/dat_i/sel_i : per-channel address/write data/byte selects (packed)
//   ch_dat_o      : last read data (shared)
//   ch_busy_o     : request pending and not completing this cycle
//   ch_done_o     : one-cycle completion pulse
//   ch_err_o      : one-cycle timeout pulse (coincident with done)
//   ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I : Wishbone master side
//
// Optional feature: define T02_WB_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT cycles without ACK. Without it the manager waits forever for ACK.
module t02_wishbone_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_CH-1:0]                ch_re_i,
    input  logic [NUM_CH-1:0]                ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]         ch_adr_i,
    input  logic [NUM_CH*DATA_W-1:0]         ch_dat_i,
    input  logic [NUM_CH*(DATA_W/8)-1:0]     ch_sel_i,
    output logic [DATA_W-1:0]                ch_dat_o,
    output logic [NUM_CH-1:0]                ch_busy_o,
    output logic [NUM_CH-1:0]                ch_done_o,
    output logic [NUM_CH-1:0]                ch_err_o,
    output logic [ADDR_W-1:0]                ADR_O,
    output logic [DATA_W-1:0]                DAT_O,
    output logic [DATA_W/8-1:0]              SEL_O,
    output logic                             WE_O,
    output logic                             STB_O,
    output logic                             CYC_O,
    input  logic [DATA_W-1:0]                DAT_I,
    input  logic                             ACK_I
);

    localparam int          SEL_W = DATA_W / 8;
    localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned N     = NUM_CH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("t02_wishbone_arbiter: unsupported NUM_CH/TIMEOUT");
    end

    logic [1:0]        state;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant;
    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   cand;
    logic              any_req;
    logic              timeout_hit;

    assign req       = ch_re_i | ch_we_i;
    assign ch_busy_o = req & ~ch_done_o;

    // Scan from farthest to nearest so the last hit is the first requesting
    // channel strictly after last_grant (modulo NUM_CH).
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            cand = CH_W'((32'(last_grant) + k) % N);
            if (req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            grant      <= '0;
            ADR_O      <= '0;
            DAT_O      <= '0;
            SEL_O      <= '0;
            WE_O       <= 1'b0;
            STB_O      <= 1'b0;
            CYC_O      <= 1'b0;
            ch_dat_o   <= '0;
            ch_done_o  <= '0;
        end else begin
            ch_done_o <= '0;
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        ADR_O      <= ch_adr_i[pick*ADDR_W +: ADDR_W];
                        DAT_O      <= ch_dat_i[pick*DATA_W +: DATA_W];
                        SEL_O      <= ch_sel_i[pick*SEL_W +: SEL_W];
                        WE_O       <= ch_we_i[pick];
                        STB_O      <= 1'b1;
                        CYC_O      <= 1'b1;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (ACK_I || timeout_hit) begin
                        // A timed-out read returns zero instead of bus data.
                        if (!WE_O) begin
                            ch_dat_o <= ACK_I ? DAT_I : '0;
                        end
                        ch_done_o[grant] <= 1'b1;
                        WE_O             <= 1'b0;
                        STB_O            <= 1'b0;
                        CYC_O            <= 1'b0;
                        state            <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef T02_WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    // to_cnt holds the number of BUS cycles already spent without ACK, so the
    // TIMEOUT-th such cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (state == BUS) && (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt   <= '0;
            ch_err_o <= '0;
        end else begin
            ch_err_o <= '0;
            if (state != BUS) begin
                to_cnt <= '0;
            end else if (!ACK_I) begin
                to_cnt <= to_cnt + 1'b1;
                if (timeout_hit) begin
                    ch_err_o[grant] <= 1'b1;
                end
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ch_err_o    = '0;
`endif

endmodule
